// File: rtl/zvc_output_encoder_pkg.sv
// Shared sizes, state encoding and element type for the ZVC output encoder.
package zvc_output_encoder_pkg;

    localparam int unsigned MEM_BW         = 128;
    localparam int unsigned ELEM_W         = 8;
    localparam int unsigned ELEMS          = MEM_BW / ELEM_W;
    localparam int unsigned WORDS_PER_MASK = MEM_BW / ELEMS;
    localparam int unsigned RES_ELEMS      = 2 * ELEMS - 1;
    localparam int unsigned RES_W          = RES_ELEMS * ELEM_W;
    localparam int unsigned CNT_W          = 5;
    localparam int unsigned GRP_W          = $clog2(WORDS_PER_MASK);

    typedef logic [ELEM_W-1:0] elem_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [GRP_W-1:0]  grp_t;
    typedef logic [1:0]        state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t FLUSH = 2'd2;

endpackage

// File: rtl/zvc_compactor.sv
// Combinational packer: gathers the non-zero elements of a dense word, lowest index
// first, and reports their count and per-element presence mask.
module zvc_compactor
    import zvc_output_encoder_pkg::*;
(
    input  logic [MEM_BW-1:0] dense,
    output logic [MEM_BW-1:0] packed_data,
    output cnt_t              nnz,
    output logic [ELEMS-1:0]  mask
);

    int unsigned idx;
    elem_t       e;

    always_comb begin
        packed_data = '0;
        mask        = '0;
        idx         = 0;
        e           = '0;
        for (int i = 0; i < ELEMS; i++) begin
            e = dense[i*ELEM_W +: ELEM_W];
            if (e != '0) begin
                mask[i]                            = 1'b1;
                packed_data[idx*ELEM_W +: ELEM_W] = e;
                idx                                = idx + 1;
            end
        end
        nnz = cnt_t'(idx);
    end

endmodule

// File: rtl/zvc_output_encoder.sv
// Zero-value-compression encoder: emits packed non-zero elements and presence masks.
// Optional ZVC_STATS_EN adds saturating non-zero and encoded-word counters.
module zvc_output_encoder
    import zvc_output_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              arst,
    input  logic [MEM_BW-1:0] dense_data,
    input  logic              dense_valid,
    input  logic              dense_last,
    output logic              dense_ready,
    output logic [MEM_BW-1:0] output_data_encoded,
    output logic              output_valid_encoded,
    output logic [MEM_BW-1:0] output_data_masks,
    output logic              output_valid_masks,
    output logic              done
`ifdef ZVC_STATS_EN
    ,
    output logic [31:0]       stat_nonzero,
    output logic [31:0]       stat_words_enc
`endif
);

    state_t            state_q, state_d;
    logic [RES_W-1:0]  res_q;
    cnt_t              cnt_q;
    logic [MEM_BW-1:0] mask_acc_q;
    grp_t              k_q;

    logic [MEM_BW-1:0] comp_data;
    cnt_t              comp_nnz;
    logic [ELEMS-1:0]  comp_mask;

    logic              xfer, flushing;
    logic [RES_W-1:0]  merged_res;
    logic [MEM_BW-1:0] merged_mask;
    cnt_t              total;
    logic              enc_full, group_full, enc_emit;

    zvc_compactor u_compactor (
        .dense       (dense_data),
        .packed_data (comp_data),
        .nnz         (comp_nnz),
        .mask        (comp_mask)
    );

    assign dense_ready = (state_q != FLUSH);
    assign xfer        = dense_valid && dense_ready;
    assign flushing    = (state_q == FLUSH);

    // Residual bytes above cnt_q are kept zero, so appending is a plain OR.
    always_comb begin
        merged_res  = res_q | (RES_W'(comp_data) << (cnt_q * ELEM_W));
        total       = cnt_q + comp_nnz;
        enc_full    = (total >= cnt_t'(ELEMS));
        merged_mask = mask_acc_q | (MEM_BW'(comp_mask) << (k_q * ELEMS));
        group_full  = (k_q == grp_t'(WORDS_PER_MASK - 1));
        enc_emit    = flushing ? (cnt_q != '0) : (xfer && enc_full);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer) state_d = dense_last ? FLUSH : RUN;
            RUN:     if (xfer && dense_last) state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q              <= IDLE;
            res_q                <= '0;
            cnt_q                <= '0;
            mask_acc_q           <= '0;
            k_q                  <= '0;
            output_data_encoded  <= '0;
            output_valid_encoded <= 1'b0;
            output_data_masks    <= '0;
            output_valid_masks   <= 1'b0;
            done                 <= 1'b0;
        end else begin
            state_q              <= state_d;
            output_valid_encoded <= 1'b0;
            output_valid_masks   <= 1'b0;
            done                 <= 1'b0;
            if (flushing) begin
                if (cnt_q != '0) begin
                    output_data_encoded  <= res_q[MEM_BW-1:0];
                    output_valid_encoded <= 1'b1;
                end
                if (k_q != '0) begin
                    output_data_masks  <= mask_acc_q;
                    output_valid_masks <= 1'b1;
                end
                res_q      <= '0;
                cnt_q      <= '0;
                mask_acc_q <= '0;
                k_q        <= '0;
                done       <= 1'b1;
            end else if (xfer) begin
                if (enc_full) begin
                    output_data_encoded  <= merged_res[MEM_BW-1:0];
                    output_valid_encoded <= 1'b1;
                    res_q                <= merged_res >> MEM_BW;
                    cnt_q                <= total - cnt_t'(ELEMS);
                end else begin
                    res_q <= merged_res;
                    cnt_q <= total;
                end
                if (group_full) begin
                    output_data_masks  <= merged_mask;
                    output_valid_masks <= 1'b1;
                    mask_acc_q         <= '0;
                    k_q                <= '0;
                end else begin
                    mask_acc_q <= merged_mask;
                    k_q        <= k_q + 1'b1;
                end
            end
        end
    end

`ifdef ZVC_STATS_EN
    logic [32:0] nz_sum;
    assign nz_sum = {1'b0, stat_nonzero} + 33'(comp_nnz);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stat_nonzero   <= '0;
            stat_words_enc <= '0;
        end else begin
            if (xfer) stat_nonzero <= nz_sum[32] ? '1 : nz_sum[31:0];
            if (enc_emit && (stat_words_enc != '1)) stat_words_enc <= stat_words_enc + 1'b1;
        end
    end
`else
    logic unused_enc_emit;
    assign unused_enc_emit = enc_emit;
`endif

endmodule

// File: tb/tb_zvc_output_encoder.sv
// Directed self-checking bench for zvc_output_encoder (stats ports when ZVC_STATS_EN).
module tb_zvc_output_encoder;
    import zvc_output_encoder_pkg::*;

    logic              clk;
    logic              arst;
    logic [MEM_BW-1:0] dense_data;
    logic              dense_valid;
    logic              dense_last;
    logic              dense_ready;
    logic [MEM_BW-1:0] output_data_encoded;
    logic              output_valid_encoded;
    logic [MEM_BW-1:0] output_data_masks;
    logic              output_valid_masks;
    logic              done;
`ifdef ZVC_STATS_EN
    logic [31:0]       stat_nonzero;
    logic [31:0]       stat_words_enc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    zvc_output_encoder dut (
        .clk                  (clk),
        .arst                 (arst),
        .dense_data           (dense_data),
        .dense_valid          (dense_valid),
        .dense_last           (dense_last),
        .dense_ready          (dense_ready),
        .output_data_encoded  (output_data_encoded),
        .output_valid_encoded (output_valid_encoded),
        .output_data_masks    (output_data_masks),
        .output_valid_masks   (output_valid_masks),
        .done                 (done)
`ifdef ZVC_STATS_EN
        ,
        .stat_nonzero         (stat_nonzero),
        .stat_words_enc       (stat_words_enc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] W_SEQ   = 128'h100F0E0D0C0B0A090807060504030201;
    localparam logic [127:0] W_A     = 128'h1A00_1900_1817_0016_0015_0014_1300_1211;
    localparam logic [127:0] W_B     = 128'h2A29_2827_2625_2423_2221_0000_0000_0000;
    localparam logic [127:0] ENC_AB  = 128'h2625_2423_2221_1A19_1817_1615_1413_1211;
    localparam logic [127:0] ENC_RB  = 128'h0000_0000_0000_0000_0000_0000_2A29_2827;
    localparam logic [127:0] MSK_AB  = 128'h0000_0000_0000_0000_0000_0000_FFC0_AD5B;
    localparam logic [127:0] ENC_RBW = 128'h0C0B_0A09_0807_0605_0403_0201_2A29_2827;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Offer one word; returns #1 after the accepting edge.
    task automatic send(input logic [127:0] d, input logic last);
        dense_data  = d;
        dense_valid = 1'b1;
        dense_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        dense_valid = 1'b0;
        dense_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        dense_valid = 1'b0;
        dense_last  = 1'b0;
        dense_data  = '0;
        arst        = 1'b1;
        @(posedge clk);
        #1;
        arst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [127:0] exp_enc[$];
    logic [127:0] got_enc[$];
    logic [127:0] exp_msk[$];
    logic [127:0] got_msk[$];
    logic [7:0]   nzb[$];
    logic [127:0] w, m;
    logic [7:0]   b;

    initial begin
        arst = 1'b1;
        dense_valid = 1'b0;
        dense_last = 1'b0;
        dense_data = '0;
        #3;
        check_eq("rst_ready", dense_ready, 1);
        check_eq("rst_enc_v", output_valid_encoded, 0);
        check_eq("rst_enc_d", output_data_encoded, 0);
        check_eq("rst_msk_v", output_valid_masks, 0);
        check_eq("rst_done", done, 0);
        do_reset();

        // All-zero stream: one zero mask word, no encoded data.
        for (int i = 0; i < 8; i++) begin
            send('0, i == 7);
            check_eq("zero_enc_v", output_valid_encoded, 0);
            check_eq("zero_msk_v", output_valid_masks, (i == 7));
        end
        check_eq("zero_msk_d", output_data_masks, 0);
        check_eq("zero_flush_ready", dense_ready, 0);
        check_eq("zero_done_early", done, 0);
        idle_cycle();
        check_eq("zero_done", done, 1);
        check_eq("zero_flush_msk_v", output_valid_masks, 0);
        check_eq("zero_flush_enc_v", output_valid_encoded, 0);
        check_eq("zero_ready_back", dense_ready, 1);
        idle_cycle();
        check_eq("zero_done_pulse", done, 0);

        // Fully dense words.
        do_reset();
        send(W_SEQ, 1'b0);
        check_eq("dense1_enc_v", output_valid_encoded, 1);
        check_eq("dense1_enc_d", output_data_encoded, W_SEQ);
        check_eq("dense1_msk_v", output_valid_masks, 0);
        send(W_SEQ, 1'b1);
        check_eq("dense2_enc_v", output_valid_encoded, 1);
        check_eq("dense2_enc_d", output_data_encoded, W_SEQ);
        idle_cycle();
        check_eq("dense_fl_msk_v", output_valid_masks, 1);
        check_eq("dense_fl_msk_d", output_data_masks, 128'hFFFF_FFFF);
        check_eq("dense_fl_enc_v", output_valid_encoded, 0);
        check_eq("dense_fl_done", done, 1);

        // Carry-over across words.
        do_reset();
        send(W_A, 1'b0);
        check_eq("carry_a_enc_v", output_valid_encoded, 0);
        send(W_B, 1'b1);
        check_eq("carry_b_enc_v", output_valid_encoded, 1);
        check_eq("carry_b_enc_d", output_data_encoded, ENC_AB);
        idle_cycle();
        check_eq("carry_fl_enc_v", output_valid_encoded, 1);
        check_eq("carry_fl_enc_d", output_data_encoded, ENC_RB);
        check_eq("carry_fl_msk_v", output_valid_masks, 1);
        check_eq("carry_fl_msk_d", output_data_masks, MSK_AB);
        check_eq("carry_fl_done", done, 1);
`ifdef ZVC_STATS_EN
        idle_cycle();
        check_eq("stat_nonzero", stat_nonzero, 20);
        check_eq("stat_words_enc", stat_words_enc, 2);
`endif

        // Back-to-back random words against a byte-stream model.
        do_reset();
        m = '0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                b = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                w[j*8 +: 8] = b;
                if (b != 8'h00) begin
                    nzb.push_back(b);
                    m[(i % 8) * 16 + j] = 1'b1;
                end
            end
            if (i % 8 == 7) begin
                exp_msk.push_back(m);
                m = '0;
            end
            check_eq("b2b_ready", dense_ready, 1);
            send(w, i == 15);
            if (output_valid_encoded) got_enc.push_back(output_data_encoded);
            if (output_valid_masks) got_msk.push_back(output_data_masks);
        end
        check_eq("b2b_flush_ready", dense_ready, 0);
        idle_cycle();
        if (output_valid_encoded) got_enc.push_back(output_data_encoded);
        if (output_valid_masks) got_msk.push_back(output_data_masks);
        check_eq("b2b_done", done, 1);
        while (nzb.size() > 0) begin
            w = '0;
            for (int j = 0; j < 16 && nzb.size() > 0; j++) w[j*8 +: 8] = nzb.pop_front();
            exp_enc.push_back(w);
        end
        check_eq("b2b_enc_count", 128'(got_enc.size()), 128'(exp_enc.size()));
        check_eq("b2b_msk_count", 128'(got_msk.size()), 128'(exp_msk.size()));
        for (int i = 0; i < exp_enc.size() && i < got_enc.size(); i++)
            check_eq("b2b_enc_d", got_enc[i], exp_enc[i]);
        for (int i = 0; i < exp_msk.size() && i < got_msk.size(); i++)
            check_eq("b2b_msk_d", got_msk[i], exp_msk[i]);

        // Reset mid-stream, then a fresh stream starts from empty state.
        do_reset();
        send(W_A, 1'b0);
        send(W_B, 1'b0);
        check_eq("mid_b_enc_d", output_data_encoded, ENC_AB);
        send(W_SEQ, 1'b0);
        check_eq("mid_c_enc_v", output_valid_encoded, 1);
        check_eq("mid_c_enc_d", output_data_encoded, ENC_RBW);
        dense_valid = 1'b0;
        #2;
        arst = 1'b1;
        #1;
        check_eq("mid_rst_enc_v", output_valid_encoded, 0);
        check_eq("mid_rst_enc_d", output_data_encoded, 0);
        check_eq("mid_rst_msk_d", output_data_masks, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_ready", dense_ready, 1);
        @(posedge clk);
        #1;
        arst = 1'b0;
        send(W_SEQ, 1'b1);
        check_eq("post_enc_v", output_valid_encoded, 1);
        check_eq("post_enc_d", output_data_encoded, W_SEQ);
        idle_cycle();
        check_eq("post_fl_enc_v", output_valid_encoded, 0);
        check_eq("post_fl_msk_v", output_valid_masks, 1);
        check_eq("post_fl_msk_d", output_data_masks, 128'hFFFF);
        check_eq("post_fl_done", done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zvc_output_encoder.md
Name: zvc_output_encoder

Overview:
- Zero-value-compression (ZVC) encoder on the accelerator output path.
- Consumes dense output-activation words from the PE array drain.
- Produces the two compressed streams carried on output_data_encoded and output_data_masks:
  - packed non-zero values;
  - one presence bit per element.
- Sits directly upstream of the off-chip output interface. That interface has no ready, so the block never stalls its outputs.

Parameters:
- MEM_BW, 128: width of every input and output data word, in bits.
- ELEM_W, 8: width of one activation element, in bits.
- ELEMS (derived), MEM_BW/ELEM_W = 16: elements per word.
- WORDS_PER_MASK (derived), MEM_BW/ELEMS = ELEM_W = 8: input words covered by one mask word.

Ports:
- clk  in  1  clock; all logic on rising edge.
- arst  in  1  reset, asynchronous, active-high.
- dense_data  in  MEM_BW  dense word; element i at bits [i*ELEM_W +: ELEM_W].
- dense_valid  in  1  dense word offered.
- dense_last  in  1  marks final word of the feature map; qualified by dense_valid.
- dense_ready  out  1  block accepts dense_data this cycle.
- output_data_encoded  out  MEM_BW  packed non-zero elements.
- output_valid_encoded  out  1  one-cycle qualifier for output_data_encoded.
- output_data_masks  out  MEM_BW  presence-bit word.
- output_valid_masks  out  1  one-cycle qualifier for output_data_masks.
- done  out  1  one-cycle pulse once the flush of a feature map completes.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port arst.
- Reset values: all outputs 0 except dense_ready = 1; state IDLE; buffers and counters cleared.
- Handshake: a transfer occurs when dense_valid && dense_ready. Outputs have no backpressure.
- States:
  - IDLE: dense_ready = 1. On a transfer, go to RUN, or to FLUSH if dense_last.
  - RUN: dense_ready = 1. On a transfer with dense_last, go to FLUSH.
  - FLUSH: dense_ready = 0. Lasts exactly one cycle, then return to IDLE with done = 1 that cycle.
- Mask path:
  - Bit i of the word mask = (element i != 0).
  - Input word k of a group (k = 0..WORDS_PER_MASK-1) fills mask bits [k*ELEMS +: ELEMS].
  - When k wraps from WORDS_PER_MASK-1 to 0, the mask word is registered out with output_valid_masks = 1 the next cycle.
- Encoded path:
  - Non-zero elements are compacted in index order, lowest index first, and appended to a residual buffer of 2*ELEMS-1 elements. cnt is a 5-bit occupancy count.
  - When cnt + nnz >= ELEMS, the lowest ELEMS elements are emitted next cycle with output_valid_encoded = 1. The remaining cnt + nnz - ELEMS elements shift down to position 0.
  - At most one encoded word per cycle. Occupancy can never exceed 2*ELEMS-1, so no stall is needed.
- Latency: exactly 1 cycle from the accepting edge to the output valid.
- FLUSH:
  - If cnt > 0, emit the residual with upper elements zero-padded.
  - If the mask group is partial (k != 0), emit it with unused bits 0.
  - Both may assert in the same cycle. If both are empty, nothing is emitted and done still pulses.
  - cnt and k are cleared.
- All-zero input word: contributes mask bits only; no encoded data.
- Simultaneous full encoded word and full mask word in one cycle: both valids assert in the same cycle.
- dense_last on a word that completes a mask group or an encoded word: that word is emitted normally on the next cycle. FLUSH then emits only a non-empty remainder.
- Reset asserted mid-operation: immediate clear, residual data discarded, no done pulse.

Optional Feature:
- Macro ZVC_STATS_EN.
- Defined:
  - Adds outputs stat_nonzero (32 bit): count of non-zero elements accepted.
  - Adds stat_words_enc (32 bit): count of encoded words emitted.
  - Both saturate at all-ones, are cleared by arst, and hold their value after done.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package: ELEM_W, ELEMS and WORDS_PER_MASK derivation.
- Shared package: the state enum {IDLE, RUN, FLUSH} and the element typedef.
- One sub-module, zvc_compactor:
  - Combinational.
  - Input: a dense word.
  - Outputs: the compacted non-zero vector, its nnz count and the ELEMS-bit mask.

Test Plan:
- All-zero stream: 8 words of 0, last on the 8th. Expected: one mask word 0x0; no encoded valid; done pulses 1 cycle after the flush.
- Fully dense: 2 words of elements 1..16, last on word 2. Expected:
  - encoded words 0x100F...0201, each one cycle after its acceptance;
  - in FLUSH, mask word with low 32 bits 0xFFFFFFFF, rest 0.
- Carry-over: word A has 10 non-zeros (values 0x11..0x1A), word B has 10 non-zeros (0x21..0x2A), last on B.
  - Cycle after B: encoded word = A's 10 values plus 0x21..0x26.
  - FLUSH: 0x27..0x2A plus 12 zero elements.
- Back-to-back 16 random words with dense_valid held high:
  - dense_ready stays 1 until FLUSH;
  - 2 mask words emitted;
  - encoded stream equals the reference model's compacted stream.
- Reset mid-stream: arst asserted after 3 words. Expected: outputs 0 within the same cycle; a new stream then encodes from k = 0 and cnt = 0.
- With ZVC_STATS_EN: carry-over scenario leaves stat_nonzero = 20 and stat_words_enc = 2.
